half_adder_structural_rep: RTL and testbench
============================================

Name: half_adder_structural_rep

Overview:
- Gate-level (structural) half adder array: each lane computes sum = a XOR b and carry = a AND b from primitive gate instances.
- Combinational results are exposed directly for zero-latency use, e.g. by small arithmetic datapaths and gate-level teaching benches.
- A registered copy with a valid flag is also provided for pipelined consumers.
- Leaf arithmetic cell; instantiated by ripple adders and other composite blocks.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1); lane i uses bit i of every vector port.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a/b for capture into the output registers.
- sum  output  WIDTH  combinational lane sum, a[i] XOR b[i].
- carry  output  WIDTH  combinational lane carry, a[i] AND b[i].
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  registered in_valid.

Behaviour:
- Combinational path:
  - sum and carry are pure gate outputs with no clock involvement and zero cycle latency.
  - Implement with one XOR primitive and one AND primitive per lane, instantiated structurally; no behavioural operators on this path.
  - Lanes are fully independent; no carry propagates between lanes.
  - sum/carry follow a/b whenever inputs change, including while rst is high; reset does not gate the combinational outputs.
- Truth table per lane (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01. sum and carry are never both 1.
- Registered path:
  - On each rising clk with rst=1: sum_q, carry_q and out_valid all go to 0.
  - On each rising clk with rst=0 and in_valid=1: sum_q<=sum, carry_q<=carry, out_valid<=1. Latency is one cycle.
  - On each rising clk with rst=0 and in_valid=0: sum_q and carry_q hold; out_valid<=0.
  - rst has priority over in_valid when both are high at the same edge.
- X/unknown inputs propagate per gate semantics. No X-scrubbing is required.
- Before the first reset edge, register contents are undefined. Benches must not check sum_q, carry_q or out_valid before reset.

Decomposition:
- No shared package needed. WIDTH is the only configuration item; no typedefs.
- One natural sub-module, half_adder_cell: a single-bit structural xor/and pair with ports a, b, sum, carry.
- The top generates WIDTH instances of half_adder_cell and adds the output register stage.

Test Plan:
- WIDTH=1, apply (a,b) = 00, 01, 10, 11, 5 ns apart -> sum/carry = 0/0, 1/0, 1/0, 0/1, each settled within the same time step as the input change.
- rst=1 for 2 cycles with a=1, b=1, in_valid=1 -> sum_q=0, carry_q=0, out_valid=0 after each edge, while combinational sum=0, carry=1 throughout.
- Release reset, then in_valid=1 with a=1, b=0 at one edge -> next cycle sum_q=1, carry_q=0, out_valid=1. Then in_valid=0 with a=1, b=1 -> sum_q/carry_q hold 1/0, out_valid=0.
- WIDTH=4, a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000, confirming no inter-lane carry. With in_valid=1, sum_q/carry_q equal these values one cycle later.
- Assert rst and in_valid together mid-stream -> registers clear to 0, and the capture is ignored at that edge.
- Exhaustive random run over all WIDTH=4 input pairs -> sum==a^b, carry==a&b every sample, and (sum & carry)==0 always.

Source files
------------

// File: rtl/half_adder_cell.sv
// half_adder_cell: single-bit half adder built only from xor/and gate primitives.
`default_nettype none

module half_adder_cell (
  input  wire logic a,
  input  wire logic b,
  output wire logic sum,
  output wire logic carry
);

  xor u_xor (sum, a, b);
  and u_and (carry, a, b);

endmodule

`default_nettype wire

// File: rtl/half_adder_structural_rep.sv
// half_adder_structural_rep: WIDTH independent structural half-adder lanes with
// zero-latency outputs plus a registered, valid-qualified copy.
`default_nettype none

module half_adder_structural_rep #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic             in_valid,
  output wire logic [WIDTH-1:0] sum,
  output wire logic [WIDTH-1:0] carry,
  output logic      [WIDTH-1:0] sum_q,
  output logic      [WIDTH-1:0] carry_q,
  output logic                  out_valid
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // Lanes share nothing, so no carry ever crosses between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  // Data registers only load on a valid beat; the valid flag itself tracks every cycle.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_half_adder_structural_rep.sv
// Scoreboarded bench for half_adder_structural_rep with a WIDTH=1 and a WIDTH=4 instance.
`default_nettype none

module tb_half_adder_structural_rep;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic       a1, b1, iv1;
  logic [3:0] a4, b4;
  logic       iv4;
  wire  logic s1, c1;
  logic       sq1, cq1, ov1;
  wire  logic [3:0] s4, c4;
  logic [3:0] sq4, cq4;
  logic       ov4;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [3:0] s;
    logic [3:0] c;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  half_adder_structural_rep #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(iv1),
    .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
  );

  half_adder_structural_rep #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .in_valid(iv4),
    .sum(s4), .carry(c4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented registered beat of the 4-lane instance is matched to the queue.
  always @(negedge clk) begin
    if (mon_en && ov4 === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got sum_q=%0h carry_q=%0h expected no beat", sq4, cq4);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_sum_q", {4'b0, sq4}, {4'b0, e.s});
        check("sb_carry_q", {4'b0, cq4}, {4'b0, e.c});
      end
    end
  end

  initial begin
    logic [1:0] vec [4];
    logic [1:0] want [4];
    vec  = '{2'b00, 2'b01, 2'b10, 2'b11};
    want = '{2'b00, 2'b10, 2'b10, 2'b01}; // {sum, carry}
    rst1 = 1'b1; rst4 = 1'b1; iv1 = 1'b0; iv4 = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;

    // Single-lane truth table on the combinational path.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = vec[i];
      #1;
      check("tt1_sum", {7'b0, s1}, {7'b0, want[i][1]});
      check("tt1_carry", {7'b0, c1}, {7'b0, want[i][0]});
      #4;
    end

    // Reset held with a capture request: registers stay clear, comb path still live.
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; iv4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_sum_q", {7'b0, sq1}, 8'h00);
      check("rst_carry_q", {7'b0, cq1}, 8'h00);
      check("rst_out_valid", {7'b0, ov1}, 8'h00);
      check("rst_comb_sum", {7'b0, s1}, 8'h00);
      check("rst_comb_carry", {7'b0, c1}, 8'h01);
      check("rst4_out_valid", {7'b0, ov4}, 8'h00);
      check("rst4_sum_q", {4'b0, sq4}, 8'h00);
    end

    rst1 = 1'b0; rst4 = 1'b0; iv4 = 1'b0;
    a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
    step();
    check("cap_sum_q", {7'b0, sq1}, 8'h01);
    check("cap_carry_q", {7'b0, cq1}, 8'h00);
    check("cap_out_valid", {7'b0, ov1}, 8'h01);
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0;
    step();
    check("hold_sum_q", {7'b0, sq1}, 8'h01);
    check("hold_carry_q", {7'b0, cq1}, 8'h00);
    check("hold_out_valid", {7'b0, ov1}, 8'h00);

    // Four-lane directed vectors, registered results go through the scoreboard.
    mon_en = 1'b1;
    a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1;
    #1;
    check("w4_sum", {4'b0, s4}, 8'b0110);
    check("w4_carry", {4'b0, c4}, 8'b1000);
    sb.push_back('{s: 4'b0110, c: 4'b1000});
    step();
    a4 = 4'b0101; b4 = 4'b0011;
    sb.push_back('{s: 4'b0110, c: 4'b0001});
    step();
    a4 = 4'b1111; b4 = 4'b0001;
    sb.push_back('{s: 4'b1110, c: 4'b0001});
    step();

    // Reset and capture together: reset wins, nothing is captured.
    rst4 = 1'b1; a4 = 4'b1001; b4 = 4'b0110; iv4 = 1'b1;
    step();
    check("rstcap_sum_q", {4'b0, sq4}, 8'h00);
    check("rstcap_carry_q", {4'b0, cq4}, 8'h00);
    check("rstcap_out_valid", {7'b0, ov4}, 8'h00);
    rst4 = 1'b0; iv4 = 1'b0;
    step();
    check("post_rst_hold", {cq4, sq4}, 8'h00);
    check("post_rst_ov", {7'b0, ov4}, 8'h00);

    // Every 4-lane input pair, each captured and scoreboarded.
    iv4 = 1'b1;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        logic [3:0] ex_s, ex_c;
        a4 = 4'(x); b4 = 4'(y);
        ex_s = 4'(x) ^ 4'(y);
        ex_c = 4'(x) & 4'(y);
        #1;
        check("ex_sum", {4'b0, s4}, {4'b0, ex_s});
        check("ex_carry", {4'b0, c4}, {4'b0, ex_c});
        check("ex_exclusive", {4'b0, s4 & c4}, 8'h00);
        sb.push_back('{s: ex_s, c: ex_c});
        step();
      end
    end

    iv4 = 1'b0; a4 = 4'h3; b4 = 4'h5;
    step();
    check("end_hold_sum_q", {4'b0, sq4}, 8'h00);
    check("end_hold_carry_q", {4'b0, cq4}, 8'h0F);
    check("end_out_valid", {7'b0, ov4}, 8'h00);
    step();
    check("sb_drained", 8'(sb.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
